// File: rtl/mult32_seq.sv
// Sequential signed multiplier using radix-2 Booth recoding over a 65-bit
// {P_hi, P_lo, q_m1} register; one add/shift iteration per clock.
module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             q_m1_q, q_m1_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH:0]   sum_s;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      p_hi_q  <= {WIDTH{1'b0}};
      p_lo_q  <= {WIDTH{1'b0}};
      q_m1_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      q_m1_q  <= q_m1_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state logic; a start pulse in any state (re)starts the operation
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = (count_q == LAST_ITER) ? DONE : RUN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Booth add/subtract on the sign-extended high word, so M = -2^(W-1) keeps its sign
  always_comb begin
    sum_s = {p_hi_q[WIDTH-1], p_hi_q};
    case ({p_lo_q[0], q_m1_q})
      2'b01:   sum_s = {p_hi_q[WIDTH-1], p_hi_q} + {m_q[WIDTH-1], m_q};
      2'b10:   sum_s = {p_hi_q[WIDTH-1], p_hi_q} - {m_q[WIDTH-1], m_q};
      default: sum_s = {p_hi_q[WIDTH-1], p_hi_q};
    endcase
  end

  // Operand load on start, otherwise one arithmetic right shift per RUN cycle
  always_comb begin
    count_d = count_q;
    m_d     = m_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    q_m1_d  = q_m1_q;
    if (ctrl_MULT) begin
      count_d = {CW{1'b0}};
      m_d     = data_operandA;
      p_hi_d  = {WIDTH{1'b0}};
      p_lo_d  = data_operandB;
      q_m1_d  = 1'b0;
    end else if (state_q == RUN) begin
      count_d = count_q + CW'(1);
      p_hi_d  = sum_s[WIDTH:1];
      p_lo_d  = {sum_s[0], p_lo_q[WIDTH-1:1]};
      q_m1_d  = p_lo_q[0];
    end else begin
      count_d = count_q;
    end
  end

  // Output logic; RDY is registered alongside the entry into DONE
  always_comb begin
    rdy_d          = (state_d == DONE);
    data_resultRDY = rdy_q;
    data_result    = p_lo_q;
    data_exception = (p_hi_q != {WIDTH{p_lo_q[WIDTH-1]}});
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected results with their
// due cycle; a negedge monitor pops and compares on each data_resultRDY.
module tb_mult32_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    longint      due;
  } exp_t;

  exp_t   sb_q[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 64-bit signed reference product
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    logic [31:0] lo;
    p     = longint'($signed(a)) * longint'($signed(b));
    lo    = p[31:0];
    e.res = lo;
    e.exc = (p != longint'($signed(lo)));
    e.due = 0;
    return e;
  endfunction

  // Monitor: compares every RDY against the scoreboard head, flags late/missing results
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rdy", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rdy_latency", cyc, e.due);
          check("result", data_result, e.res);
          check("exception", data_exception, e.exc);
        end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
        e = sb_q.pop_front();
        check("rdy_timeout", cyc, e.due);
      end
    end
  end

  // Drive a one-cycle start pulse (inputs change 2 time units after posedge)
  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic exc);
    exp_t e;
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    e.res = res;
    e.exc = exc;
    e.due = cyc + 33;
    sb_q.push_back(e);
    @(posedge clock);
    #2;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic start_model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(a, b);
    pulse(a, b, e.res, e.exc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("wait_idle_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corner [6];
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1;
    check("reset_result", data_result, 0);
    check("reset_exception", data_exception, 0);
    check("reset_rdy", data_resultRDY, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;

    // Directed cases with hand-derived expectations
    pulse(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    wait_idle();
    pulse(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    wait_idle();
    pulse(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    wait_idle();
    pulse(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    wait_idle();
    pulse(32'd0, 32'h8000_0000, 32'd0, 1'b0);
    wait_idle();

    // Restart mid-run: only the second operation may produce RDY
    pulse(32'd5, 32'd6, 32'd30, 1'b0);
    repeat (9) begin
      @(posedge clock);
      #2;
    end
    void'(sb_q.pop_back());
    pulse(32'hFFFF_FFFC, 32'd9, 32'hFFFF_FFDC, 1'b0);
    wait_idle();

    // Reset mid-run clears outputs at once and suppresses RDY
    pulse(32'd3, 32'd4, 32'd12, 1'b0);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("midreset_result", data_result, 0);
    check("midreset_exception", data_exception, 0);
    check("midreset_rdy", data_resultRDY, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #2;
    check("post_reset_idle_result", data_result, 0);

    // Back-to-back: result held in IDLE, then restart immediately after RDY
    pulse(32'd1000, 32'hFFFF_FF00, 32'hFFFC_1800, 1'b0);
    wait_idle();
    check("held_result", data_result, 32'hFFFC_1800);
    pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle();

    // Corner pairs then random signed sweep against the 64-bit model
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h8000_0000;
    corner[5] = 32'h0001_0000;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        start_model(corner[i], corner[j]);
        wait_idle();
      end
    end
    for (int k = 0; k < 1000; k++) begin
      a = $urandom();
      b = $urandom();
      if (k % 3 == 0) b = 32'($signed($urandom_range(0, 65535)) - 32768);
      if (k % 5 == 0) a = 32'($signed($urandom_range(0, 65535)) - 32768);
      start_model(a, b);
      wait_idle();
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
